// File: rtl/rsa_io_pkg.sv
// Shared types and constants for the RSA stream bridge.
// Beat-count width helper sizes the input word counter.
package rsa_io_pkg;

    localparam int OP_W  = 1024;
    localparam int EXP_W = 16;

    typedef enum logic [2:0] {
        LOAD,
        START,
        GUARD,
        WAIT,
        UNLOAD
    } state_t;

    function automatic int beat_cnt_w(input int nw);
        return $clog2(4 * nw + 1);
    endfunction

endpackage

// File: rtl/rsa_word_serializer.sv
// Parallel-load shift register streamed out LS word first.
// Raises last on the final output handshake.
module rsa_word_serializer #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [OP_W-1:0]   din,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              last
);

    localparam int NW  = OP_W / WORD_W;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;

    logic [OP_W-1:0] sh;
    logic [WCW-1:0]  wcnt;

    assign m_data = sh[WORD_W-1:0];
    assign last   = m_valid && m_ready &&
                    (wcnt == WCW'(NW - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh      <= '0;
            wcnt    <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            sh      <= din;
            wcnt    <= '0;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            sh <= sh >> WORD_W;
            if (last) begin
                m_valid <= 1'b0;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_io_bridge.sv
// Stream front/back end for montgomery_exp: load, start, unload.
// RSA_IO_ODD_CHECK_EN: reject even moduli and flag err.
module rsa_io_bridge #(
    parameter int WORD_W = 32,
    parameter int OP_W   = rsa_io_pkg::OP_W
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [WORD_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [WORD_W-1:0]           m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        core_start,
    output logic [OP_W-1:0]             core_msg,
    output logic [OP_W-1:0]             core_n,
    output logic [OP_W-1:0]             core_rmodn,
    output logic [OP_W-1:0]             core_r2modn,
    output logic [rsa_io_pkg::EXP_W-1:0] core_exp,
    input  logic [OP_W-1:0]             core_result,
    input  logic                        core_done,
    output logic                        busy,
    output logic                        err
);

    import rsa_io_pkg::*;

    localparam int NW = OP_W / WORD_W;
    localparam int CW = beat_cnt_w(NW);
    localparam logic [CW-1:0] LAST_BEAT = CW'(4 * NW);
    localparam logic [CW-1:0] NW_C = CW'(NW);

    if (WORD_W < 16 || OP_W % WORD_W != 0) begin : g_bad_cfg
        $error("rsa_io_bridge: WORD_W must be >=16 and divide OP_W");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   beat_idx;
    logic [CW-1:0]   word_k;
    logic [1:0]      op_sel;
    logic            guard_q;
    logic            s_ready_q;
    logic            err_q;
    logic            load;
    logic            odd_fail;
    logic            last;
    logic [OP_W-1:0] load_data;

    // Beat 0 is the header; beats 1..4*NW map to operand/word.
    always_comb begin
        beat_idx = cnt - 1'b1;
        op_sel   = 2'(beat_idx / NW_C);
        word_k   = beat_idx % NW_C;
    end

    assign s_ready = s_ready_q;
    assign err     = err_q;

`ifdef RSA_IO_ODD_CHECK_EN
    assign odd_fail = (state == START) && !core_n[0];
`else
    assign odd_fail = 1'b0;
`endif

    assign load      = odd_fail || (state == WAIT && core_done);
    assign load_data = odd_fail ? '0 : core_result;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= LOAD;
            cnt         <= '0;
            guard_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            busy        <= 1'b0;
            err_q       <= 1'b0;
            core_start  <= 1'b0;
            core_exp    <= '0;
            core_msg    <= '0;
            core_n      <= '0;
            core_rmodn  <= '0;
            core_r2modn <= '0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                LOAD: begin
                    s_ready_q <= 1'b1;
                    if (s_valid && s_ready_q) begin
                        if (cnt == '0) begin
                            core_exp <= s_data[EXP_W-1:0];
                            err_q    <= 1'b0;
                        end else begin
                            unique case (op_sel)
                                2'd0: core_msg[word_k*WORD_W +: WORD_W] <= s_data;
                                2'd1: core_n[word_k*WORD_W +: WORD_W] <= s_data;
                                2'd2: core_rmodn[word_k*WORD_W +: WORD_W] <= s_data;
                                2'd3: core_r2modn[word_k*WORD_W +: WORD_W] <= s_data;
                            endcase
                        end
                        if (cnt == LAST_BEAT) begin
                            cnt       <= '0;
                            state     <= START;
                            s_ready_q <= 1'b0;
                            busy      <= 1'b1;
`ifdef RSA_IO_ODD_CHECK_EN
                            core_start <= core_n[0];
`else
                            core_start <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    guard_q <= 1'b0;
`ifdef RSA_IO_ODD_CHECK_EN
                    if (!core_n[0]) begin
                        state <= UNLOAD;
                        err_q <= 1'b1;
                    end else begin
                        state <= GUARD;
                    end
`else
                    state <= GUARD;
`endif
                end
                // A stale done from the previous job may linger here.
                GUARD: begin
                    if (guard_q) begin
                        state <= WAIT;
                    end else begin
                        guard_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        state <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (last) begin
                        state     <= LOAD;
                        busy      <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    rsa_word_serializer #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W)
    ) u_ser (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .din     (load_data),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .last    (last)
    );

endmodule

// File: doc/rsa_io_bridge.md
# rsa_io_bridge

Stream-side front/back end for the RSA exponentiation core. It accepts one job as a sequence of narrow words on a valid/ready input stream and assembles the exponent, message, modulus, R mod N and R² mod N. It pulses the core's start, waits for the core's done, then serializes the 1024-bit result back out on a valid/ready output stream. It sits directly between the host/DMA interface and `montgomery_exp`, and handles one job at a time.

## Interface
- `WORD_W`, default 32: stream word width; must divide `OP_W` and be ≥16. Any other value is an elaboration error.
- `OP_W`, default 1024: operand width; `NW = OP_W/WORD_W` words per operand.
- `clk`  in  1  clock.
- `resetn`  in  1  reset: synchronous, active-low.
- `s_data`  in  WORD_W  input stream word.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  bridge accepts an input word.
- `m_data`  out  WORD_W  result stream word.
- `m_valid`  out  1  result word valid.
- `m_ready`  in  1  sink accepts a result word.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_msg`, `core_n`, `core_rmodn`, `core_r2modn`  out  OP_W each  core operands.
- `core_exp`  out  16  exponent.
- `core_result`  in  OP_W  core result.
- `core_done`  in  1  core done; level signal, held high until the next start.
- `busy`  out  1  high in START, GUARD, WAIT and UNLOAD.
- `err`  out  1  modulus-check error flag (see Configuration).

## Operation
- Input order, least-significant word first within each operand:
  - header word: bits [15:0] are the exponent; the upper bits are ignored.
  - then `msg`, then `n`, then `rmodn`, then `r2modn`, NW words each.
  - Total `1+4·NW` beats (129 at defaults).
- Beat counter `cnt` runs 0..4·NW. Word k of operand j goes to bits [k·WORD_W +: WORD_W] of operand register j.
- Operand registers change only on accepted LOAD beats. They are stable from START until the first beat of the next job.
- States and transitions:
  - LOAD: `s_ready`=1. On the last handshake → START.
  - START: `core_start`=1 for exactly this cycle → GUARD.
  - GUARD: two cycles. `core_done` is ignored here, because the core's done from the previous job may still be high → WAIT.
  - WAIT: on the first cycle `core_done`=1, `core_result` is captured into the output shift register → UNLOAD.
  - UNLOAD: `m_valid`=1 and `m_data` = shift register [WORD_W-1:0]. Each handshake shifts right by WORD_W. After NW handshakes → LOAD with `cnt`=0.
- `core_done` seen in LOAD, START or GUARD: ignored.
- `s_valid` gaps and `m_ready` back-pressure stall the bridge indefinitely; data is neither lost nor duplicated.
- Reset mid-operation: every state, counter and register returns to its reset value, and any partial job is discarded. The core is reset by the same `resetn`.

## Timing
- Values while `resetn`=0:
  - state = LOAD, `s_ready`=0.
  - `m_valid`=0, `core_start`=0, `busy`=0, `err`=0.
  - All operands, `core_exp`, `m_data` = 0.
- `s_ready`=1 from the first cycle after `resetn` goes high.
- `s_ready` and `m_valid` are decoded from the registered state only; there is no combinational path from input to output.
- `core_start` is high in the cycle immediately after the last input handshake.
- Result latency: the first `m_valid` appears 1 cycle after WAIT sees `core_done`=1.
- Throughput with no stalls: NW cycles to stream the result out; `s_ready` returns to 1 in the cycle after the last output handshake.

## Configuration
- `RSA_IO_ODD_CHECK_EN` defined:
  - In the START cycle, if `core_n[0]`=0 (even modulus, invalid for Montgomery), `core_start` is suppressed.
  - State goes directly to UNLOAD with an all-zero shift register, and `err` is set.
  - `err` is sticky until the first beat of the next job is accepted.
- `RSA_IO_ODD_CHECK_EN` undefined: `err` is tied to 0 and the core is always started.

## Structure
- Package `rsa_io_pkg`: `OP_W`=1024, `EXP_W`=16, the state enum typedef (LOAD, START, GUARD, WAIT, UNLOAD), and the beat-count width function.
- Sub-module `rsa_word_serializer`: parallel load plus a WORD_W-wide valid/ready shift-out. It owns the output shift register, the word counter and the `m_*` ports, and asserts `last` on the final handshake.
- Everything else lives in a single top: the FSM, the input demux and the operand registers.

## Test plan
- Bench uses a stub core whose result is `msg ^ n`, with done 10 cycles after start.
- Basic job: header 0x0001_0003, `msg`=2, `n`=0x…F1, `rmodn`/`r2modn`=1, no stalls → `core_exp`=3, `core_msg`=2, one `core_start` pulse, 32 output words equal to `2 ^ n`, least-significant word first.
- Input gaps: random `s_valid`, 50% duty → operands bit-identical to the basic job, exactly one `core_start`.
- Back-pressure: `m_ready` low for 20 cycles mid-UNLOAD → `m_data` held constant, no word lost or repeated, `s_ready` stays 0 until the last word is accepted.
- Stale done: stub holds `core_done`=1 from the previous job through the next START → no capture in GUARD; capture happens only after the stub deasserts and reasserts done.
- Reset at beat 70 of LOAD, then a full new job → output matches the new job only, with no residue from the aborted one.
- With `RSA_IO_ODD_CHECK_EN` defined, `n`=0x…F0 → no `core_start`, 32 zero words output, `err`=1 until the next header beat is accepted.
